// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the iterative multiply/divide unit: widths,
// iteration count and FSM state encoding.
package mdu_ctrl_pkg;
  localparam int XLEN       = 32;
  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic [XLEN-1:0] neg_word(input logic [XLEN-1:0] v);
    return ~v + XLEN'(1);
  endfunction
endpackage

// File: rtl/mdu_ctrl_md_iter.sv
// Iterative datapath: one 33-bit adder shared by radix-2 shift-add multiply
// and restoring shift-subtract divide. Exposes next-step values.
module md_iter
  import mdu_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic            div_mode,
  input  logic [XLEN-1:0] load_lo,
  input  logic [XLEN-1:0] load_op,
  output logic [XLEN-1:0] hi_next,
  output logic [XLEN-1:0] lo_next
);
  logic [XLEN-1:0] hi_reg, lo_reg, op_reg;
  logic [XLEN:0]   add_a, add_b, sum;
  logic            cin;

  // Divide: subtract divisor from the shifted partial remainder; a set
  // bit 32 of the difference means it went negative, so restore.
  always_comb begin
    if (div_mode) begin
      add_a = {hi_reg, lo_reg[XLEN-1]};
      add_b = ~{1'b0, op_reg};
      cin   = 1'b1;
    end else begin
      add_a = {1'b0, hi_reg};
      add_b = lo_reg[0] ? {1'b0, op_reg} : '0;
      cin   = 1'b0;
    end
    sum = add_a + add_b + {{XLEN{1'b0}}, cin};
    if (div_mode) begin
      hi_next = sum[XLEN] ? add_a[XLEN-1:0] : sum[XLEN-1:0];
      lo_next = {lo_reg[XLEN-2:0], ~sum[XLEN]};
    end else begin
      hi_next = sum[XLEN:1];
      lo_next = {sum[0], lo_reg[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_reg <= '0;
      lo_reg <= '0;
      op_reg <= '0;
    end else if (load) begin
      hi_reg <= '0;
      lo_reg <= load_lo;
      op_reg <= load_op;
    end else if (step) begin
      hi_reg <= hi_next;
      lo_reg <= lo_next;
    end
  end
endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: FSM, iteration counter and sign correction
// around md_iter. Define MDU_DIV0_BYPASS_EN to finish divide-by-zero at once.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mul_start_i,
  input  logic            mul_cancel_i,
  input  logic            mul_signed_i,
  input  logic [XLEN-1:0] mul_op1_i,
  input  logic [XLEN-1:0] mul_op2_i,
  output logic            mul_stop_o,
  output logic [XLEN-1:0] mul_res_l_o,
  output logic [XLEN-1:0] mul_res_h_o,
  input  logic            div_start_i,
  input  logic            div_cancel_i,
  input  logic            div_op1_signed_i,
  input  logic            div_op2_signed_i,
  input  logic [XLEN-1:0] div_op1_i,
  input  logic [XLEN-1:0] div_op2_i,
  output logic            div_stop_o,
  output logic [XLEN-1:0] div_res_o,
  output logic [XLEN-1:0] div_rem_o
);
  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic              op_div_reg, mul_neg_reg, q_neg_reg, r_neg_reg, div_zero_reg;
  logic              mul_stop_reg, div_stop_reg;
  logic [XLEN-1:0]   mul_res_l_reg, mul_res_h_reg, div_res_reg, div_rem_reg;
  logic              cancel, accept_mul, accept_div, bypass_div, load, step, finish;
  logic [XLEN-1:0]   iter_hi, iter_lo;
  logic [2*XLEN-1:0] product, product_fixed;
  logic [XLEN-1:0]   quot_fixed, rem_fixed, bypass_rem;

  assign cancel = mul_cancel_i | div_cancel_i;
  assign load   = accept_mul | accept_div;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    accept_mul = 1'b0;
    accept_div = 1'b0;
    bypass_div = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!cancel) begin
          if (mul_start_i) begin
            accept_mul = 1'b1;
            state_next = ST_MUL;
          end else if (div_start_i) begin
            accept_div = 1'b1;
`ifdef MDU_DIV0_BYPASS_EN
            if (div_op2_i == '0) begin
              bypass_div = 1'b1;
              state_next = ST_DONE;
            end else begin
              state_next = ST_DIV;
            end
`else
            state_next = ST_DIV;
`endif
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (cancel) begin
          state_next = ST_IDLE;
        end else begin
          step = 1'b1;
          if (cnt_reg == CNT_W'(ITER_COUNT - 1)) begin
            finish     = 1'b1;
            state_next = ST_DONE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  md_iter u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .step     (step),
    .div_mode (op_div_reg),
    .load_lo  (accept_mul ? mul_op2_i : div_op1_i),
    .load_op  (accept_mul ? mul_op1_i : div_op2_i),
    .hi_next  (iter_hi),
    .lo_next  (iter_lo)
  );

  // Zero divisor leaves the natural all-ones quotient, but it must not be
  // sign-flipped, hence the override.
  always_comb begin
    product       = {iter_hi, iter_lo};
    product_fixed = mul_neg_reg ? (~product + 64'd1) : product;
    quot_fixed    = div_zero_reg ? '1 : (q_neg_reg ? neg_word(iter_lo) : iter_lo);
    rem_fixed     = r_neg_reg ? neg_word(iter_hi) : iter_hi;
    bypass_rem    = div_op1_signed_i ? neg_word(div_op1_i) : div_op1_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg       <= '0;
      op_div_reg    <= 1'b0;
      mul_neg_reg   <= 1'b0;
      q_neg_reg     <= 1'b0;
      r_neg_reg     <= 1'b0;
      div_zero_reg  <= 1'b0;
      mul_stop_reg  <= 1'b0;
      div_stop_reg  <= 1'b0;
      mul_res_l_reg <= '0;
      mul_res_h_reg <= '0;
      div_res_reg   <= '0;
      div_rem_reg   <= '0;
    end else begin
      if (load) begin
        cnt_reg      <= '0;
        op_div_reg   <= accept_div;
        mul_neg_reg  <= mul_signed_i;
        q_neg_reg    <= div_op1_signed_i ^ div_op2_signed_i;
        r_neg_reg    <= div_op1_signed_i;
        div_zero_reg <= (div_op2_i == '0);
      end else if (step) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
      mul_stop_reg <= finish & ~op_div_reg;
      div_stop_reg <= (finish & op_div_reg) | bypass_div;
      if (finish && !op_div_reg) begin
        mul_res_l_reg <= product_fixed[XLEN-1:0];
        mul_res_h_reg <= product_fixed[2*XLEN-1:XLEN];
      end
      if (finish && op_div_reg) begin
        div_res_reg <= quot_fixed;
        div_rem_reg <= rem_fixed;
      end
      if (bypass_div) begin
        div_res_reg <= '1;
        div_rem_reg <= bypass_rem;
      end
    end
  end

  assign mul_stop_o  = mul_stop_reg;
  assign div_stop_o  = div_stop_reg;
  assign mul_res_l_o = mul_res_l_reg;
  assign mul_res_h_o = mul_res_h_reg;
  assign div_res_o   = div_res_reg;
  assign div_rem_o   = div_rem_reg;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: directed corner cases plus random multiply
// and divide requests checked against an arithmetic reference model.
module tb_mdu_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mul_start = 1'b0, mul_cancel = 1'b0, mul_signed = 1'b0;
  logic [31:0] mul_op1 = '0, mul_op2 = '0;
  logic        div_start = 1'b0, div_cancel = 1'b0, div_s1 = 1'b0, div_s2 = 1'b0;
  logic [31:0] div_op1 = '0, div_op2 = '0;
  logic        mul_stop, div_stop;
  logic [31:0] mul_res_l, mul_res_h, div_res, div_rem;

  mdu_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .mul_start_i(mul_start), .mul_cancel_i(mul_cancel), .mul_signed_i(mul_signed),
    .mul_op1_i(mul_op1), .mul_op2_i(mul_op2),
    .mul_stop_o(mul_stop), .mul_res_l_o(mul_res_l), .mul_res_h_o(mul_res_h),
    .div_start_i(div_start), .div_cancel_i(div_cancel),
    .div_op1_signed_i(div_s1), .div_op2_signed_i(div_s2),
    .div_op1_i(div_op1), .div_op2_i(div_op2),
    .div_stop_o(div_stop), .div_res_o(div_res), .div_rem_o(div_rem)
  );

`ifdef MDU_DIV0_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_mul;
    int          stop_cyc;
    logic [31:0] r0;
    logic [31:0] r1;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0, n_bad = 0;
  int          idle_cyc = 0;
  logic [31:0] last_ml = '0, last_mh = '0, last_q = '0, last_r = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain arithmetic on magnitudes, then the sign rules.
  task automatic model(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                       input bit s1, input bit s2,
                       output logic [31:0] r0, output logic [31:0] r1);
    logic [63:0] p;
    logic [31:0] q, r;
    if (is_mul) begin
      p = 64'(a) * 64'(b);
      if (s1) p = 64'd0 - p;
      r0 = p[31:0];
      r1 = p[63:32];
    end else if (b == 0) begin
      r0 = 32'hFFFF_FFFF;
      r1 = s1 ? 32'd0 - a : a;
    end else begin
      q = a / b;
      r = a % b;
      r0 = (s1 ^ s2) ? 32'd0 - q : q;
      r1 = s1 ? 32'd0 - r : r;
    end
  endtask

  // Monitor: every stop pulse must match the oldest outstanding request.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n && (mul_stop || div_stop)) begin
      if (sb.size() == 0) begin
        chk("unexpected_stop", {30'd0, mul_stop, div_stop}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("stop_kind", {30'd0, mul_stop, div_stop}, mon_e.is_mul ? 32'd2 : 32'd1);
        chk("stop_cycle", cyc, mon_e.stop_cyc);
        if (mon_e.is_mul) begin
          chk("mul_res_l", mul_res_l, mon_e.r0);
          chk("mul_res_h", mul_res_h, mon_e.r1);
          last_ml = mon_e.r0;
          last_mh = mon_e.r1;
        end else begin
          chk("div_res", div_res, mon_e.r0);
          chk("div_rem", div_rem, mon_e.r1);
          last_q = mon_e.r0;
          last_r = mon_e.r1;
        end
        $display("txn %s stop@%0d res=%h_%h", mon_e.is_mul ? "mul" : "div", cyc,
                 mon_e.is_mul ? mul_res_h : div_rem, mon_e.is_mul ? mul_res_l : div_res);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    while (cyc < idle_cyc) tick();
  endtask

  task automatic check_held(input string tag);
    chk({tag, "_mul_l"}, mul_res_l, last_ml);
    chk({tag, "_mul_h"}, mul_res_h, last_mh);
    chk({tag, "_div_q"}, div_res, last_q);
    chk({tag, "_div_r"}, div_rem, last_r);
  endtask

  task automatic issue(input bit is_mul, input bit both, input logic [31:0] a,
                       input logic [31:0] b, input bit s1, input bit s2, input int hold);
    exp_t e;
    int   acc;
    bit   byp;
    if (cyc >= idle_cyc) check_held("held");
    acc      = (cyc > idle_cyc) ? cyc : idle_cyc;
    e.is_mul = is_mul || both;
    model(e.is_mul, a, b, s1, s2, e.r0, e.r1);
    byp        = !e.is_mul && (b == 0) && BYPASS;
    e.stop_cyc = acc + (byp ? 1 : 33);
    sb.push_back(e);
    if (is_mul || both) begin
      mul_start = 1'b1; mul_op1 = a; mul_op2 = b; mul_signed = s1;
    end
    if (!is_mul || both) begin
      div_start = 1'b1; div_op1 = a; div_op2 = b; div_s1 = s1; div_s2 = s2;
    end
    do tick(); while (cyc <= acc + (byp ? 0 : hold));
    mul_start = 1'b0;
    div_start = 1'b0;
    mul_op1 = $urandom; mul_op2 = $urandom; mul_signed = 1'($urandom);
    div_op1 = $urandom; div_op2 = $urandom; div_s1 = 1'($urandom); div_s2 = 1'($urandom);
    idle_cyc = e.stop_cyc + 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    repeat (3) tick();
    check_held("reset");
    chk("reset_stops", {30'd0, mul_stop, div_stop}, 32'd0);
    rst_n = 1'b1;
    idle_cyc = cyc;

    issue(1, 0, 32'd7, 32'd6, 0, 0, 0);
    issue(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 3);
    issue(1, 0, 32'd3, 32'd5, 1, 0, 0);
    wait_idle();
    issue(0, 0, 32'd7, 32'd2, 1, 0, 5);
    issue(0, 0, 32'd20, 32'd0, 0, 0, 0);
    wait_idle();
    issue(0, 0, 32'h8000_0000, 32'd1, 1, 0, 0);
    issue(1, 1, 32'd9, 32'd4, 0, 0, 2);
    wait_idle();

    // Divide cancelled at iteration 10, mul accepted the next cycle.
    div_start = 1'b1; div_op1 = 32'd1000; div_op2 = 32'd7; div_s1 = 1'b0; div_s2 = 1'b0;
    tick();
    div_start = 1'b0;
    repeat (10) tick();
    div_cancel = 1'b1;
    tick();
    div_cancel = 1'b0;
    idle_cyc = cyc;
    issue(1, 0, 32'd12345, 32'd678, 0, 0, 0);
    wait_idle();

    // Cancel and start together in IDLE: nothing accepted.
    mul_start = 1'b1; mul_cancel = 1'b1; mul_op1 = 32'd5; mul_op2 = 32'd5;
    tick();
    mul_start = 1'b0; mul_cancel = 1'b0;
    repeat (40) tick();
    check_held("cancel_idle");
    idle_cyc = cyc;

    // Reset at iteration 15 of a multiply.
    mul_start = 1'b1; mul_op1 = 32'd77; mul_op2 = 32'd99; mul_signed = 1'b0;
    tick();
    mul_start = 1'b0;
    repeat (15) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mul_l", mul_res_l, 32'd0);
    chk("rst_mul_h", mul_res_h, 32'd0);
    chk("rst_div_q", div_res, 32'd0);
    chk("rst_div_r", div_rem, 32'd0);
    chk("rst_stops", {30'd0, mul_stop, div_stop}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    last_ml = '0; last_mh = '0; last_q = '0; last_r = '0;
    idle_cyc = cyc;
    issue(0, 0, 32'd100, 32'd9, 0, 1, 0);

    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
      b = ($urandom_range(0, 6) == 0) ? 32'd0 :
          ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 300)) : 32'($urandom);
      if ($urandom_range(0, 1) == 1) wait_idle();
      issue(1'($urandom), ($urandom_range(0, 9) == 0), a, b,
            1'($urandom), 1'($urandom), $urandom_range(0, 20));
    end
    wait_idle();
    repeat (3) tick();
    chk("pending", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have ports, clock and reset first: clk in 1, single clock, all state on rising edge; rst_n in 1, reset, asynchronous, active-low.
REQ-002 SHALL have mul_start_i in 1 (multiply request, held high until stop), mul_cancel_i in 1 (abort), mul_signed_i in 1 (negate final product), mul_op1_i in 32, mul_op2_i in 32 (magnitudes).
REQ-003 SHALL have mul_stop_o out 1 (one-cycle done pulse), mul_res_l_o out 32, mul_res_h_o out 32 (product low/high).
REQ-004 SHALL have div_start_i in 1, div_cancel_i in 1, div_op1_signed_i in 1, div_op2_signed_i in 1 (original operand signs), div_op1_i in 32 (dividend magnitude), div_op2_i in 32 (divisor magnitude).
REQ-005 SHALL have div_stop_o out 1, div_res_o out 32 (quotient), div_rem_o out 32 (remainder).

Function
REQ-006 SHALL implement FSM states IDLE, MUL, DIV, DONE; one shared 33-bit add/sub datapath, 6-bit iteration counter.
REQ-007 IDLE: mul_start_i high (no cancel) latches operands/sign, counter=0, next MUL; else div_start_i high latches, next DIV; mul wins if both high.
REQ-008 MUL: radix-2 shift-add, one multiplier bit per cycle; after 32 iterations next DONE.
REQ-009 DIV: restoring shift-subtract, one quotient bit per cycle; after 32 iterations next DONE.
REQ-010 DONE: sign-correct, register results, assert matching stop for exactly one cycle, next IDLE.
REQ-011 Latency: start sampled in IDLE at cycle t -> stop high at cycle t+33; results valid in that cycle.
REQ-012 Results held stable from stop until next accepted start; stop low in all non-DONE cycles.
REQ-013 Product: 64-bit unsigned product of magnitudes, two's-complement negated over 64 bits when mul_signed_i latched high.
REQ-014 Quotient negated when op1_signed xor op2_signed; remainder negated when op1_signed.
REQ-015 Divisor zero: quotient 0xFFFFFFFF, remainder = dividend with its original sign.
REQ-016 Magnitude 0x80000000 / 1 with opposite signs SHALL yield quotient 0x80000000, remainder 0.
REQ-017 Cancel (mul_cancel_i or div_cancel_i) in any state -> IDLE next cycle, no stop pulse, result outputs unchanged.
REQ-018 Cancel and start in the same IDLE cycle: cancel wins, request not accepted.
REQ-019 start deassertion mid-operation SHALL be ignored (operation completes); start re-sampled only in IDLE.
REQ-020 start held high in DONE cycle SHALL NOT be accepted until following IDLE cycle.

Reset
REQ-021 rst_n low SHALL immediately force IDLE, counter 0, stop outputs 0, all result outputs 0, including mid-operation.
REQ-022 First accept after reset release SHALL behave identically to any other accept.

Configuration
REQ-023 Macro MDU_DIV0_BYPASS_EN defined: divisor-zero divide goes IDLE -> DONE directly, stop at t+1, results per REQ-015.
REQ-024 Macro undefined: divisor-zero divide runs full 32 iterations, stop at t+33, results identical per REQ-015.

Structure
REQ-025 State encodings, iteration count (32), and operand/result width macros SHALL live in the shared defines.v header.
REQ-026 Iterative add/sub/shift datapath SHALL be sub-module md_iter; FSM, counter, sign correction stay in mdu_ctrl.

Verification
REQ-027 mul 7 x 6, signed=0 at t -> mul_stop_o at t+33, res_l 0x0000002A, res_h 0.
REQ-028 mul magnitudes 0xFFFFFFFF x 0xFFFFFFFF, signed=0 -> res_h 0xFFFFFFFE, res_l 0x00000001; magnitudes 3 x 5, signed=1 -> res_h 0xFFFFFFFF, res_l 0xFFFFFFF1.
REQ-029 div -7/2 (op1 mag 7, op1_signed=1) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; 20/0 -> 0xFFFFFFFF, 20, stop at t+1 with MDU_DIV0_BYPASS_EN, t+33 without.
REQ-030 div start, cancel at iteration 10 -> IDLE next cycle, no stop, previous results unchanged; new mul accepted next cycle completes normally.
REQ-031 rst_n low at iteration 15 -> outputs 0 immediately; mul and div start high simultaneously -> mul accepted, only mul_stop_o pulses.
